// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core memory port: access control codes, port
// ownership and the arbiter's state encoding.
package mem_port_arbiter_pkg;

  typedef logic [31:0] rvwordT;

  typedef enum logic [1:0] {
    MEM_INVALID = 2'd0,
    MEM_READ    = 2'd1,
    MEM_WRITE   = 2'd2
  } MemControlT;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } MemOwnerT;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } ArbStateT;

  // Instruction fetches always read a whole word.
  localparam logic [3:0] BE_FULL_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_pick.sv
// Selects which requester drives the memory port this cycle. Data wins
// by default; fetch wins once data has taken MAX_DATA_STREAK grants in a
// row while fetch was waiting. A locked owner keeps the port until its
// handshake, and nobody is selected while a response is outstanding.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK_W        = 3,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                if_valid,
  input  logic                dm_valid,
  input  logic [STREAK_W-1:0] streak,
  input  ArbStateT            state,
  input  MemOwnerT            locked_owner,
  output MemOwnerT            owner_sel
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  // Owner selection per arbiter state.
  always_comb begin
    // NOTE: default assignment first so no path leaves owner_sel unassigned (no latch).
    owner_sel = OWN_NONE;
    case (state)
      ARB_IDLE: begin
        if (dm_valid && !(if_valid && (streak == STREAK_MAX))) begin
          owner_sel = OWN_DATA;
        end else if (if_valid) begin
          owner_sel = OWN_FETCH;
        end
      end
      ARB_ISSUE: owner_sel = locked_owner;
      default:   owner_sel = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the
// load/store path. One transaction is outstanding at a time; its
// response is routed back to whichever requester issued it. Fetch
// responses belonging to a flushed epoch are swallowed.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output rvwordT            if_rsp_data,
  input  logic              dm_req_valid,
  input  MemControlT        dm_req_ctrl,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  rvwordT            dm_req_wdata,
  input  logic [3:0]        dm_req_be,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output rvwordT            dm_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output MemControlT        mem_req_ctrl,
  output logic [ADDR_W-1:0] mem_req_addr,
  output rvwordT            mem_req_wdata,
  output logic [3:0]        mem_req_be,
  input  logic              mem_rsp_valid,
  input  rvwordT            mem_rsp_data,
  output logic              err_invalid_ctrl
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  ArbStateT            state;
  MemOwnerT            owner;
  MemOwnerT            picked;
  MemOwnerT            sel;
  logic [STREAK_W-1:0] streak;
  logic                drop;
  logic                is_store;

  logic dm_discard;
  logic drive_fetch;
  logic drive_data;
  logic handshake;
  logic rsp_in_wait;
  logic fetch_rsp;

  mem_arb_pick #(
    .STREAK_W        (STREAK_W),
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_pick (
    .if_valid     (if_req_valid),
    .dm_valid     (dm_req_valid),
    .streak       (streak),
    .state        (state),
    .locked_owner (owner),
    .owner_sel    (picked)
  );

  // While reset is held nobody may see a grant, even with requests pending.
  assign sel = rst ? OWN_NONE : picked;

  // A data request carrying MEM_INVALID is accepted and dropped without touching memory.
  assign dm_discard  = (state == ARB_IDLE) && (sel == OWN_DATA) && (dm_req_ctrl == MEM_INVALID);
  assign drive_fetch = (sel == OWN_FETCH);
  assign drive_data  = (sel == OWN_DATA) && !dm_discard;

  assign mem_req_valid = drive_fetch || drive_data;
  assign handshake     = mem_req_valid && mem_req_ready;
  assign if_req_ready  = drive_fetch && mem_req_ready;
  assign dm_req_ready  = (drive_data && mem_req_ready) || dm_discard;

  // Memory request fields follow the selected requester; idle port is all zero.
  always_comb begin
    mem_req_ctrl  = MEM_INVALID;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_be    = '0;
    if (drive_fetch) begin
      mem_req_ctrl = MEM_READ;
      mem_req_addr = if_req_addr;
      mem_req_be   = BE_FULL_WORD;
    end else if (drive_data) begin
      mem_req_ctrl  = dm_req_ctrl;
      mem_req_addr  = dm_req_addr;
      mem_req_wdata = dm_req_wdata;
      mem_req_be    = dm_req_be;
    end
  end

  // Responses pass straight through to the owner; stray responses outside ARB_WAIT are ignored.
  assign rsp_in_wait  = (state == ARB_WAIT) && mem_rsp_valid;
  assign fetch_rsp    = rsp_in_wait && (owner == OWN_FETCH);
  assign if_rsp_valid = fetch_rsp && !drop && !if_flush;
  assign if_rsp_data  = if_rsp_valid ? mem_rsp_data : '0;
  assign dm_rsp_valid = rsp_in_wait && (owner == OWN_DATA);
  assign dm_rsp_data  = (dm_rsp_valid && !is_store) ? mem_rsp_data : '0;

  // Transaction FSM: lock the winner until handshake, then wait for its response.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= OWN_NONE;
      is_store <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (mem_req_valid) begin
            owner    <= sel;
            is_store <= drive_data && (dm_req_ctrl == MEM_WRITE);
            state    <= mem_req_ready ? ARB_WAIT : ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_req_ready) state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (mem_rsp_valid) begin
            state <= ARB_IDLE;
            owner <= OWN_NONE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Fairness streak: counts data grants taken while fetch was waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (handshake) begin
      if (drive_data && if_req_valid) begin
        streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
      end else begin
        streak <= '0;
      end
    end
  end

  // Drop flag: remember a flush seen after the stale fetch was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (fetch_rsp) begin
      drop <= 1'b0;
    end else if (if_flush && (((state == ARB_WAIT) && (owner == OWN_FETCH)) ||
                              (handshake && drive_fetch))) begin
      drop <= 1'b1;
    end
  end

  // Sticky error for data requests with no valid access type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_invalid_ctrl <= 1'b0;
    end else if (dm_discard) begin
      err_invalid_ctrl <= 1'b1;
    end
  end

endmodule
